// File: rtl/mvm_pkg.sv
`default_nettype none
// ============================================================================
// mvm_pkg : shared types, default sizes and width helper for the MVM sequencer
// Rev 1.0
// ============================================================================
package mvm_pkg;

  localparam int DEF_M = 4;
  localparam int DEF_N = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COMPUTE = 3'd1,
    S_DRAIN   = 3'd2,
    S_OUTPUT  = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  function automatic int m_addr_width(input int m, input int n);
    return (m * n > 1) ? $clog2(m * n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_mvm_addr_gen.sv
`default_nettype none
// ============================================================================
// ctrl_mvm_addr_gen : row/col counters and x/m memory read address generation
// Rev 1.0
// ============================================================================
module ctrl_mvm_addr_gen
  import mvm_pkg::*;
#(
  parameter int M            = DEF_M,
  parameter int N            = DEF_N,
  parameter int X_ADDR_WIDTH = $clog2(N),
  parameter int M_ADDR_WIDTH = m_addr_width(M, N)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear_i,
  input  logic                    col_inc_i,
  input  logic                    row_inc_i,
  output logic                    col_first_o,
  output logic                    col_last_o,
  output logic                    row_last_o,
  output logic [X_ADDR_WIDTH-1:0] rd_addr_x_o,
  output logic [M_ADDR_WIDTH-1:0] rd_addr_m_o
);

  localparam int ROW_W = (M > 1) ? $clog2(M) : 1;

  logic [X_ADDR_WIDTH-1:0] col_q, col_d;
  logic [ROW_W-1:0]        row_q, row_d;

  // Row advance wins over column advance so col wraps to 0 on every new row.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear_i) begin
      col_d = '0;
      row_d = '0;
    end else if (row_inc_i) begin
      col_d = '0;
      row_d = row_q + ROW_W'(1);
    end else if (col_inc_i) begin
      col_d = col_q + X_ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_first_o = (col_q == '0);
  assign col_last_o  = (col_q == X_ADDR_WIDTH'(N - 1));
  assign row_last_o  = (row_q == ROW_W'(M - 1));
  assign rd_addr_x_o = col_q;
  assign rd_addr_m_o = M_ADDR_WIDTH'(row_q) * M_ADDR_WIDTH'(N) + M_ADDR_WIDTH'(col_q);

endmodule
`default_nettype wire

// File: rtl/ctrl_mvm_seq.sv
`default_nettype none
// ============================================================================
// ctrl_mvm_seq : matrix-vector multiply sequencer (memory walk, MAC strobes, y handshake)
// Rev 1.0
// ============================================================================
module ctrl_mvm_seq
  import mvm_pkg::*;
#(
  parameter int M            = DEF_M,
  parameter int N            = DEF_N,
  parameter int X_ADDR_WIDTH = $clog2(N),
  parameter int M_ADDR_WIDTH = m_addr_width(M, N)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [X_ADDR_WIDTH:0]   x_count,
  input  logic [M_ADDR_WIDTH:0]   m_count,
  output logic                    en_ext_ctrl,
  output logic                    clr_counts,
  output logic [X_ADDR_WIDTH-1:0] rd_addr_x,
  output logic [M_ADDR_WIDTH-1:0] rd_addr_m,
  output logic                    mac_en,
  output logic                    clear_acc,
  output logic                    y_valid,
  input  logic                    y_ready,
  output logic                    done
);

  localparam logic [X_ADDR_WIDTH:0] X_FULL = (X_ADDR_WIDTH + 1)'(N);
  localparam logic [M_ADDR_WIDTH:0] M_FULL = (M_ADDR_WIDTH + 1)'(M * N);

  state_e state_q, state_d;
  logic   prev_done_q;
  logic   en_q;
  logic   mac_en_q, clear_acc_q;

  logic   cnt_clear, col_inc, row_inc;
  logic   issue, issue_first;
  logic   col_first, col_last, row_last;
  logic   load_ok;

  ctrl_mvm_addr_gen #(
    .M            (M),
    .N            (N),
    .X_ADDR_WIDTH (X_ADDR_WIDTH),
    .M_ADDR_WIDTH (M_ADDR_WIDTH)
  ) u_addr_gen (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (cnt_clear),
    .col_inc_i    (col_inc),
    .row_inc_i    (row_inc),
    .col_first_o  (col_first),
    .col_last_o   (col_last),
    .row_last_o   (row_last),
    .rd_addr_x_o  (rd_addr_x),
    .rd_addr_m_o  (rd_addr_m)
  );

  // The counts seen right after DONE are stale until the clear lands, so skip that cycle.
  assign load_ok = (x_count == X_FULL) && (m_count == M_FULL) && !prev_done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      prev_done_q <= 1'b0;
      en_q        <= 1'b0;
      mac_en_q    <= 1'b0;
      clear_acc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_done_q <= (state_q == S_DONE);
      en_q        <= (state_d != S_IDLE);
      mac_en_q    <= issue;
      clear_acc_q <= issue_first;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (load_ok) state_d = S_COMPUTE;
      S_COMPUTE: if (col_last) state_d = S_DRAIN;
      S_DRAIN:   state_d = S_OUTPUT;
      S_OUTPUT:  if (y_ready) state_d = row_last ? S_DONE : S_COMPUTE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_clear   = (state_q == S_IDLE) || (state_q == S_DONE);
    col_inc     = (state_q == S_COMPUTE) && !col_last;
    row_inc     = (state_q == S_OUTPUT) && y_ready && !row_last;
    issue       = (state_q == S_COMPUTE);
    issue_first = (state_q == S_COMPUTE) && col_first;
    y_valid     = (state_q == S_OUTPUT);
    done        = (state_q == S_DONE);
    clr_counts  = (state_q == S_DONE);
  end

  // Read data arrives one cycle after the address, so the MAC strobes trail by one register.
  assign mac_en      = mac_en_q;
  assign clear_acc   = clear_acc_q;
  assign en_ext_ctrl = en_q;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_mvm_seq.sv
`default_nettype none
// ============================================================================
// tb_ctrl_mvm_seq : directed + randomized bench against a row/phase reference model
// Rev 1.0
// ============================================================================
module tb_ctrl_mvm_seq;

  localparam int M  = 4;
  localparam int N  = 4;
  localparam int XW = 2;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [XW:0]   x_count;
  logic [MW:0]   m_count;
  logic          y_ready;
  logic          en_ext_ctrl, clr_counts, mac_en, clear_acc, y_valid, done;
  logic [XW-1:0] rd_addr_x;
  logic [MW-1:0] rd_addr_m;

  always #5 clk = ~clk;

  ctrl_mvm_seq #(
    .M            (M),
    .N            (N),
    .X_ADDR_WIDTH (XW),
    .M_ADDR_WIDTH (MW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .x_count      (x_count),
    .m_count      (m_count),
    .en_ext_ctrl  (en_ext_ctrl),
    .clr_counts   (clr_counts),
    .rd_addr_x    (rd_addr_x),
    .rd_addr_m    (rd_addr_m),
    .mac_en       (mac_en),
    .clear_acc    (clear_acc),
    .y_valid      (y_valid),
    .y_ready      (y_ready),
    .done         (done)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference model: mode 0 idle, 1 running a row, 2 finishing.
  // k counts cycles since the row's first read; k >= N+1 means the y element is on offer.
  int md_mode = 0;
  int md_row  = 0;
  int md_k    = 0;
  bit md_after_fin = 1'b0;

  int mac_cnt, clr_cnt;
  int accepts[$];
  int done_cyc[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic check_outputs();
    bit run, fin;
    run = (md_mode == 1);
    fin = (md_mode == 2);
    check_eq("en_ext_ctrl", 32'(en_ext_ctrl), 32'(run || fin));
    check_eq("done",        32'(done),        32'(fin));
    check_eq("clr_counts",  32'(clr_counts),  32'(fin));
    check_eq("y_valid",     32'(y_valid),     32'(run && md_k >= N + 1));
    check_eq("mac_en",      32'(mac_en),      32'(run && md_k >= 1 && md_k <= N));
    check_eq("clear_acc",   32'(clear_acc),   32'(run && md_k == 1));
    if (run && md_k < N) begin
      check_eq("rd_addr_x", 32'(rd_addr_x), md_k);
      check_eq("rd_addr_m", 32'(rd_addr_m), md_row * N + md_k);
    end else if (md_mode == 0) begin
      check_eq("idle_addr_x", 32'(rd_addr_x), 0);
      check_eq("idle_addr_m", 32'(rd_addr_m), 0);
    end
  endtask

  task automatic model_step();
    case (md_mode)
      0: begin
        if (x_count == N && m_count == M * N && !md_after_fin) begin
          md_mode = 1;
          md_row  = 0;
          md_k    = 0;
        end
        md_after_fin = 1'b0;
      end
      1: begin
        if (md_k >= N + 1) begin
          if (y_ready) begin
            if (md_row == M - 1) md_mode = 2;
            else begin
              md_row++;
              md_k = 0;
            end
          end
        end else begin
          md_k++;
        end
      end
      default: begin
        md_mode      = 0;
        md_after_fin = 1'b1;
      end
    endcase
  endtask

  // Called at a falling edge: check this cycle, drive the next inputs, advance the model.
  task automatic tick(input bit yr, input int xc, input int mc);
    check_outputs();
    if (mac_en === 1'b1) mac_cnt++;
    if (clear_acc === 1'b1) clr_cnt++;
    if (done === 1'b1) done_cyc.push_back(cyc);
    y_ready = yr;
    x_count = (XW + 1)'(xc);
    m_count = (MW + 1)'(mc);
    if (y_valid === 1'b1 && yr) accepts.push_back(cyc);
    model_step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check_eq("rst_en_ext_ctrl", 32'(en_ext_ctrl), 0);
    check_eq("rst_clr_counts",  32'(clr_counts),  0);
    check_eq("rst_rd_addr_x",   32'(rd_addr_x),   0);
    check_eq("rst_rd_addr_m",   32'(rd_addr_m),   0);
    check_eq("rst_mac_en",      32'(mac_en),      0);
    check_eq("rst_clear_acc",   32'(clear_acc),   0);
    check_eq("rst_y_valid",     32'(y_valid),     0);
    check_eq("rst_done",        32'(done),        0);
    md_mode      = 0;
    md_row       = 0;
    md_k         = 0;
    md_after_fin = 1'b0;
    @(negedge clk);
    cyc++;
    reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int stall;
    int n0;
    bit reached;
    reset   = 1'b0;
    y_ready = 1'b0;
    x_count = '0;
    m_count = '0;
    @(negedge clk);
    do_reset();

    // Full run with y_ready held high.
    mac_cnt = 0;
    clr_cnt = 0;
    accepts.delete();
    done_cyc.delete();
    for (int i = 0; i < 80 && done_cyc.size() == 0; i++) tick(1'b1, N, M * N);
    check_eq("t1_done_seen", done_cyc.size(), 1);
    check_eq("t1_accepts", accepts.size(), M);
    check_eq("t1_mac_cycles", mac_cnt, M * N);
    check_eq("t1_clear_cycles", clr_cnt, M);
    if (accepts.size() == M) begin
      for (int i = 1; i < M; i++) check_eq("t1_row_spacing", accepts[i] - accepts[i-1], N + 2);
      if (done_cyc.size() == 1) check_eq("t1_done_latency", done_cyc[0] - accepts[M-1], 1);
    end
    tick(1'b1, N, M * N);  // still-full counts right after DONE must not relaunch
    tick(1'b1, 0, 0);
    tick(1'b1, 0, 0);

    // m memory one word short: must stay idle, then launch once it fills.
    repeat (5) tick(1'b1, N, M * N - 1);
    check_eq("t2_idle_en", 32'(en_ext_ctrl), 0);
    stall = 0;
    n0 = done_cyc.size();
    for (int i = 0; i < 100 && done_cyc.size() == n0; i++) begin
      if (md_mode == 1 && md_row == 1 && md_k >= N + 1 && stall < 5) begin
        stall++;
        tick(1'b0, N, M * N);
      end else begin
        tick(1'b1, N, M * N);
      end
    end
    check_eq("t2_stall_cycles", stall, 5);
    check_eq("t2_done_seen", done_cyc.size(), n0 + 1);
    tick(1'b1, 0, 0);
    tick(1'b1, 0, 0);

    // Reset in the second COMPUTE cycle of row 2, then restart from address 0.
    reached = 1'b0;
    for (int i = 0; i < 60 && !reached; i++) begin
      tick(1'b1, N, M * N);
      reached = (md_mode == 1 && md_row == 2 && md_k == 1);
    end
    check_eq("t3_reached_row2", 32'(reached), 1);
    do_reset();
    n0 = done_cyc.size();
    for (int i = 0; i < 80 && done_cyc.size() == n0; i++) tick(1'b1, N, M * N);
    check_eq("t3_rerun_done", done_cyc.size(), n0 + 1);
    tick(1'b1, 0, 0);
    tick(1'b1, 0, 0);

    // Randomized: mostly-full counts, random back-pressure, rare resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 3) != 0) begin
        tick(1'($urandom_range(0, 1)), N, M * N);
      end else begin
        tick(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 31)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ctrl_mvm_seq.md
Name: ctrl_mvm_seq

Overview:
Sequencer for the matrix-vector multiply datapath. It waits until the x memory (N words) and m memory (M*N words) are fully loaded by their write controllers, then walks the memories row by row. It drives the MAC enable/clear and presents each y element on a valid/ready output handshake. While it owns the memories it holds en_ext_ctrl high, so the write controllers freeze their counters and gate writes.

Parameters:
M, 4, number of matrix rows (= number of y outputs)
N, 4, number of columns (= x vector length)
X_ADDR_WIDTH, $clog2(N), x memory address width
M_ADDR_WIDTH, $clog2(M*N), m memory address width

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
x_count  input  X_ADDR_WIDTH+1  words written to x memory (from x write controller)
m_count  input  M_ADDR_WIDTH+1  words written to m memory (from m write controller)
en_ext_ctrl  output  1  high whenever the block is not IDLE; freezes the write controllers
clr_counts  output  1  one-cycle pulse in DONE; synchronous clear of both write counters
rd_addr_x  output  X_ADDR_WIDTH  x memory read address
rd_addr_m  output  M_ADDR_WIDTH  m memory read address
mac_en  output  1  accumulate enable to the MAC
clear_acc  output  1  load the accumulator with the product instead of adding (qualified by mac_en)
y_valid  output  1  the accumulator holds a finished y element
y_ready  input  1  downstream accepts y
done  output  1  one-cycle pulse when all M outputs have been accepted

Behaviour:
- Reset (reset==0, async):
  - state=IDLE; row and col counters = 0.
  - All outputs 0, including both addresses.
  - A reset mid-operation abandons the run. No y_valid is held across reset.
- Memory read latency is 1 cycle. mac_en/clear_acc are the read-issue strobe delayed by one register stage.
- IDLE:
  - Leave when x_count==N and m_count==M*N, both sampled in the same cycle; next state is COMPUTE with row=0, col=0.
  - Otherwise stay in IDLE.
- COMPUTE (N cycles, col=0..N-1):
  - rd_addr_x=col; rd_addr_m=row*N+col.
  - col increments each cycle. When col==N-1, go to DRAIN.
- DRAIN (1 cycle):
  - Last mac_en of the row is asserted here.
- Accumulator strobe timing:
  - clear_acc=1 exactly with the mac_en that follows the col==0 read.
  - mac_en is high for exactly N consecutive cycles per row: COMPUTE cycles 2..N plus DRAIN.
- OUTPUT:
  - y_valid=1. Stay while y_ready==0; y_valid must not drop and the accumulator must not be touched (mac_en=0).
  - On y_valid&&y_ready: if row==M-1 go to DONE; else row+1, col=0, go to COMPUTE.
- DONE (1 cycle):
  - done=1, clr_counts=1, then IDLE.
  - en_ext_ctrl drops on entry to IDLE.
  - A load condition still true in that IDLE cycle is ignored, because the counters were cleared.
- en_ext_ctrl = (state!=IDLE), registered from next state so it rises in the first COMPUTE cycle.
- Per-row latency with y_ready tied 1: N+2 cycles. y_valid first rises N+1 cycles after leaving IDLE.
- Widths:
  - row*N+col is computed at M_ADDR_WIDTH bits; no overflow for legal row/col.
  - col wraps to 0 at row change, never past N-1.
- Simultaneous events:
  - y_ready arriving in the same cycle y_valid rises is a valid transfer (1-cycle OUTPUT).
  - x_count/m_count changes while not IDLE are ignored.

Decomposition:
- Package mvm_pkg:
  - state enum (IDLE, COMPUTE, DRAIN, OUTPUT, DONE).
  - Default M/N localparams.
  - Function for the m address width.
- One sub-module, ctrl_mvm_addr_gen: row/col counters and the rd_addr_x/rd_addr_m computation, with inc/clear inputs from the FSM.
- The FSM and the mac strobe pipeline stay in ctrl_mvm_seq.

Test Plan:
- Reset then x_count=4, m_count=16, y_ready=1 (M=N=4):
  - rd_addr_m sequence 0..15, rd_addr_x repeats 0..3.
  - 4 y_valid pulses, each 6 cycles apart; done pulse 1 cycle after the 4th accept; clr_counts coincident with done.
- Per-row strobe check:
  - Per row exactly 4 mac_en cycles.
  - clear_acc only on the first; none during OUTPUT.
- Only x_count=4 (m_count=15):
  - Stays IDLE, en_ext_ctrl=0, no reads.
  - Raise m_count to 16: COMPUTE starts next cycle.
- y_ready held 0 for 5 cycles on row 1:
  - y_valid stays high 5+ cycles; mac_en=0; addresses stable.
  - Accept on cycle 6 resumes with rd_addr_m=8.
- Assert reset in the 2nd COMPUTE cycle of row 2:
  - All outputs 0 immediately (async).
  - After release with counts still full, the sequence restarts from rd_addr_m=0.
- y_ready=1 before y_valid rises:
  - Transfer occurs in the first OUTPUT cycle; OUTPUT lasts exactly 1 cycle.
